// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and defaults for the data-memory arbiter.
// Owner tags for the read-return path, FSM state type and counter sizing helper.
package dmem_arbiter_pkg;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_ACC  = 1'b1;

  localparam int DEF_MAX_WAIT  = 4;
  localparam int DEF_MAX_BURST = 8;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_ACC_BURST = 1'b1
  } state_t;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Clear takes priority over increment; the count sticks at MAX.
module sat_counter #(
  parameter int WIDTH = 3,
  parameter int MAX   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single dmem BRAM port between the core EX-stage path and the
// convolution accelerator: core priority, bounded acc wait, capped acc bursts.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AWIDTH    = 14,
  parameter int MAX_WAIT  = DEF_MAX_WAIT,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic [31:0]       core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [3:0]        core_we,
  output logic              core_stall,
  output logic [31:0]       core_rdata,
  output logic              core_rvalid,
  input  logic              acc_req,
  input  logic [31:0]       acc_addr,
  input  logic [31:0]       acc_wdata,
  input  logic [3:0]        acc_we,
  input  logic              acc_last,
  output logic              acc_gnt,
  output logic [31:0]       acc_rdata,
  output logic              acc_rvalid,
  output logic              dmem_en,
  output logic [AWIDTH-1:0] dmem_addr,
  output logic [31:0]       dmem_din,
  output logic [3:0]        dmem_we,
  input  logic [31:0]       dmem_dout
);

  localparam int WW = cnt_width(MAX_WAIT);
  localparam int BW = cnt_width(MAX_BURST - 1);

  state_t          state_q;
  state_t          state_d;
  logic            core_grant;
  logic            acc_grant;
  logic            yield_q;
  logic            force_yield;
  logic [WW-1:0]   wait_cnt;
  logic [BW-1:0]   beat_cnt;
  logic            wait_full;
  logic            burst_full;
  logic            rd_valid_q;
  logic            rd_owner_q;
  logic [31:0]     core_hold_q;
  logic [31:0]     acc_hold_q;
  logic            unused_addr_bits;

  assign wait_full   = (wait_cnt == WW'(MAX_WAIT));
  assign burst_full  = (beat_cnt == BW'(MAX_BURST - 1));
  assign force_yield = (state_q == ST_ACC_BURST) && acc_grant && burst_full && core_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      yield_q <= 1'b0;
    end else begin
      state_q <= state_d;
      yield_q <= force_yield;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (acc_grant && !acc_last) state_d = ST_ACC_BURST;
      ST_ACC_BURST: if (!acc_req || acc_last || force_yield) state_d = ST_IDLE;
    endcase
  end

  // Grants are suppressed entirely while reset is held so the BRAM stays quiet.
  always_comb begin
    core_grant = 1'b0;
    acc_grant  = 1'b0;
    if (!rst) begin
      if (state_q == ST_IDLE) begin
        if (acc_req && (!core_req || wait_full) && !yield_q) acc_grant = 1'b1;
        else if (core_req)                                   core_grant = 1'b1;
        else if (acc_req)                                    acc_grant = 1'b1;
      end else begin
        if (acc_req)       acc_grant  = 1'b1;
        else if (core_req) core_grant = 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(WW), .MAX(MAX_WAIT)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (acc_req && !acc_grant),
    .clr   (!acc_req || acc_grant),
    .count (wait_cnt)
  );

  sat_counter #(.WIDTH(BW), .MAX(MAX_BURST - 1)) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (acc_grant),
    .clr   (state_d == ST_IDLE),
    .count (beat_cnt)
  );

  assign core_stall = core_req && !core_grant;
  assign acc_gnt    = acc_grant;

  assign dmem_en   = core_grant || acc_grant;
  assign dmem_addr = acc_grant ? acc_addr[AWIDTH+1:2] : core_addr[AWIDTH+1:2];
  assign dmem_din  = acc_grant ? acc_wdata : core_wdata;
  assign dmem_we   = acc_grant ? acc_we : (core_grant ? core_we : 4'h0);

  assign unused_addr_bits = ^{core_addr[31:AWIDTH+2], core_addr[1:0],
                              acc_addr[31:AWIDTH+2], acc_addr[1:0]};

  // Remember who issued the read so next cycle's BRAM data goes to the right side.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_owner_q <= OWN_CORE;
    end else begin
      rd_valid_q <= dmem_en && (dmem_we == 4'h0);
      rd_owner_q <= acc_grant ? OWN_ACC : OWN_CORE;
    end
  end

  assign core_rvalid = rd_valid_q && (rd_owner_q == OWN_CORE) && !rst;
  assign acc_rvalid  = rd_valid_q && (rd_owner_q == OWN_ACC) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      core_hold_q <= '0;
      acc_hold_q  <= '0;
    end else begin
      if (core_rvalid) core_hold_q <= dmem_dout;
      if (acc_rvalid)  acc_hold_q  <= dmem_dout;
    end
  end

  assign core_rdata = core_rvalid ? dmem_dout : core_hold_q;
  assign acc_rdata  = acc_rvalid ? dmem_dout : acc_hold_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a BRAM model and a read-return scoreboard.
// Every read the bench expects to be granted is queued and matched one cycle later.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  typedef struct {
    logic        owner;
    logic [31:0] data;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_we;
  logic        core_stall;
  logic [31:0] core_rdata;
  logic        core_rvalid;
  logic        acc_req;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_we;
  logic        acc_last;
  logic        acc_gnt;
  logic [31:0] acc_rdata;
  logic        acc_rvalid;
  logic        dmem_en;
  logic [13:0] dmem_addr;
  logic [31:0] dmem_din;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_dout;

  logic [31:0] bram   [0:16383];
  logic [31:0] shadow [0:16383];
  rd_exp_t     sb[$];
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;

  dmem_arbiter #(.AWIDTH(14), .MAX_WAIT(4), .MAX_BURST(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .core_req    (core_req),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_we     (core_we),
    .core_stall  (core_stall),
    .core_rdata  (core_rdata),
    .core_rvalid (core_rvalid),
    .acc_req     (acc_req),
    .acc_addr    (acc_addr),
    .acc_wdata   (acc_wdata),
    .acc_we      (acc_we),
    .acc_last    (acc_last),
    .acc_gnt     (acc_gnt),
    .acc_rdata   (acc_rdata),
    .acc_rvalid  (acc_rvalid),
    .dmem_en     (dmem_en),
    .dmem_addr   (dmem_addr),
    .dmem_din    (dmem_din),
    .dmem_we     (dmem_we),
    .dmem_dout   (dmem_dout)
  );

  always #5 clk = ~clk;

  // Read-first BRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (dmem_en) begin
      dmem_dout <= bram[dmem_addr];
      for (int i = 0; i < 4; i++)
        if (dmem_we[i]) bram[dmem_addr][8*i +: 8] <= dmem_din[8*i +: 8];
    end
  end

  function automatic logic [31:0] pat(input int w);
    return 32'h5A000000 | 32'(w);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected) passes = passes + 1;
    else begin
      fails = fails + 1;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic c_req, input logic [31:0] c_addr, input logic [31:0] c_wdata,
                               input logic [3:0] c_we, input logic a_req, input logic [31:0] a_addr,
                               input logic [31:0] a_wdata, input logic [3:0] a_we, input logic a_last);
    core_req   = c_req;
    core_addr  = c_addr;
    core_wdata = c_wdata;
    core_we    = c_we;
    acc_req    = a_req;
    acc_addr   = a_addr;
    acc_wdata  = a_wdata;
    acc_we     = a_we;
    acc_last   = a_last;
  endtask

  // Match this cycle's rvalid/rdata against what was queued the cycle before.
  task automatic checkReads();
    rd_exp_t e;
    if (rst) begin
      if (sb.size() > 0) sb.delete(0);
      checkOutput("rvalid_in_reset", {30'b0, core_rvalid, acc_rvalid}, 32'd0);
    end else if (sb.size() == 0) begin
      checkOutput("no_rvalid", {30'b0, core_rvalid, acc_rvalid}, 32'd0);
    end else begin
      e = sb.pop_front();
      checkOutput("rvalid_owner", {30'b0, core_rvalid, acc_rvalid}, (e.owner == OWN_ACC) ? 32'd1 : 32'd2);
      checkOutput("rdata", (e.owner == OWN_ACC) ? acc_rdata : core_rdata, e.data);
    end
  endtask

  task automatic step(input string tag, input logic exp_core, input logic exp_acc);
    logic [31:0] g_addr;
    logic [31:0] g_din;
    logic [3:0]  g_we;
    int          w;
    rd_exp_t     e;
    @(negedge clk);
    checkReads();
    checkOutput({tag, "_stall"}, 32'(core_req && !exp_core), 32'(core_stall));
    checkOutput({tag, "_acc_gnt"}, 32'(acc_gnt), 32'(exp_acc));
    checkOutput({tag, "_en"}, 32'(dmem_en), 32'(exp_core || exp_acc));
    g_addr = exp_acc ? acc_addr : core_addr;
    g_din  = exp_acc ? acc_wdata : core_wdata;
    g_we   = exp_acc ? acc_we : (exp_core ? core_we : 4'h0);
    checkOutput({tag, "_we"}, 32'(dmem_we), 32'(g_we));
    if (exp_core || exp_acc) begin
      w = int'(g_addr[15:2]);
      checkOutput({tag, "_addr"}, 32'(dmem_addr), 32'(g_addr[15:2]));
      if (g_we != 4'h0) begin
        checkOutput({tag, "_din"}, dmem_din, g_din);
        for (int i = 0; i < 4; i++)
          if (g_we[i]) shadow[w][8*i +: 8] = g_din[8*i +: 8];
      end else begin
        e.owner = exp_acc ? OWN_ACC : OWN_CORE;
        e.data  = shadow[w];
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      bram[i]   = pat(i);
      shadow[i] = pat(i);
    end

    // Reset with both sides requesting: nothing may reach the BRAM.
    rst = 1'b1;
    applyStimulus(1'b1, 32'h100, 32'h0, 4'h0, 1'b1, 32'h400, 32'h0, 4'h0, 1'b0);
    step("rst0", 1'b0, 1'b0);
    step("rst1", 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    step("idle", 1'b0, 1'b0);
    checkOutput("state_after_reset", 32'(dut.state_q), 32'(ST_IDLE));
    checkOutput("wait_after_reset", 32'(dut.wait_cnt), 32'd0);

    // Core-only reads on consecutive cycles.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4*i), 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      step("core_rd", 1'b1, 1'b0);
    end
    checkOutput("core_rd_addr_last", 32'(dmem_addr), 32'h42);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    step("core_drain", 1'b0, 1'b0);

    // Continuous contention: acc forced through after four denied cycles.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h300 + 32'(4*i), 32'h0, 4'h0, 1'b1, 32'h400, 32'h0, 4'h0, 1'b1);
      step("contend", i < 4, i == 4);
      if (i == 3) checkOutput("wait_saturated", 32'(dut.wait_cnt), 32'd4);
    end
    checkOutput("wait_cleared", 32'(dut.wait_cnt), 32'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    step("contend_drain", 1'b0, 1'b0);

    // Ten-beat burst, core arrives at beat 2: 8 beats, one core slot, then resume.
    for (int k = 0; k < 11; k++) begin
      int b;
      b = (k <= 7) ? k : k - 1;
      applyStimulus((k >= 2) && (k <= 8), 32'h1000, 32'h0, 4'h0,
                    1'b1, 32'h800 + 32'(4*b), 32'h0, 4'h0, b == 9);
      step("burst", k == 8, k != 8);
      if (k == 7) checkOutput("yield_set", 32'(dut.yield_q), 32'd1);
    end
    checkOutput("burst_end_state", 32'(dut.state_q), 32'(ST_IDLE));
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    step("burst_drain", 1'b0, 1'b0);

    // Short burst ending on acc_last, then an immediate core access.
    for (int b = 0; b < 3; b++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hA00 + 32'(4*b), 32'h0, 4'h0, b == 2);
      step("short_burst", 1'b0, 1'b1);
    end
    checkOutput("short_burst_state", 32'(dut.state_q), 32'(ST_IDLE));
    applyStimulus(1'b1, 32'hA04, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    step("early_core", 1'b1, 1'b0);

    // Acc write followed by a core read of the same word.
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h200, 32'hDEADBEEF, 4'hF, 1'b1);
    step("acc_wr", 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h200, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    step("core_rd_after_wr", 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    step("wr_drain", 1'b0, 1'b0);
    checkOutput("core_rdata_hold", core_rdata, 32'hDEADBEEF);

    // Reset arriving on beat 3 of an acc read burst.
    for (int b = 0; b < 3; b++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hC00 + 32'(4*b), 32'h0, 4'h0, 1'b0);
      step("rst_burst", 1'b0, 1'b1);
    end
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hC0C, 32'h0, 4'h0, 1'b0);
    step("rst_beat", 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    step("post_rst", 1'b0, 1'b0);
    checkOutput("post_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    checkOutput("post_rst_beat", 32'(dut.beat_cnt), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data-memory port between two requesters: the core's EX-stage load/store path and the convolution accelerator's streaming master. The core normally has priority. The accelerator gets bounded-wait fairness and non-preemptible bursts of limited length. The block sits between the EX/MEM boundary and the dmem BRAM, and raises a core stall when the core loses arbitration.

Parameters:
AWIDTH, 14, dmem word-address width; dmem_addr = byte_addr[AWIDTH+1:2]
MAX_WAIT, 4, cycles a pending accelerator request may be denied before it is forced through
MAX_BURST, 8, accelerator beats per burst before a forced yield to a waiting core

Ports:
clk  in  1  clock
rst  in  1  reset
core_req  in  1  core access valid this cycle
core_addr  in  32  core byte address
core_wdata  in  32  core write data, already lane-shifted
core_we  in  4  core byte write enables; 0 = read
core_stall  out  1  core request not granted this cycle; hold pipeline
core_rdata  out  32  read data returned to core
core_rvalid  out  1  core_rdata valid
acc_req  in  1  accelerator beat valid
acc_addr  in  32  accelerator byte address
acc_wdata  in  32  accelerator write data
acc_we  in  4  accelerator byte enables; 0 = read
acc_last  in  1  final beat of the current burst
acc_gnt  out  1  accelerator beat accepted this cycle
acc_rdata  out  32  read data returned to accelerator
acc_rvalid  out  1  acc_rdata valid
dmem_en  out  1  BRAM enable
dmem_addr  out  AWIDTH  BRAM word address
dmem_din  out  32  BRAM write data
dmem_we  out  4  BRAM byte write enables
dmem_dout  in  32  BRAM read data, 1-cycle latency

Behaviour:
- Clocking and reset: single clock clk. rst is synchronous and active-high.
- Reset state: state=IDLE, wait_cnt=0, beat_cnt=0, yield=0, rd_owner valid=0.
- Outputs during reset: core_rvalid=0, acc_rvalid=0, acc_gnt=0. dmem_en is gated low while rst is asserted.
- State machine: state in {IDLE, ACC_BURST}. Grant is combinational from state, counters and the request inputs. All counters and the state are registered.
- Grant rules in IDLE (priority order):
  - acc_req && (!core_req || wait_cnt==MAX_WAIT) && !yield -> grant acc.
  - Otherwise core_req -> grant core.
  - Otherwise acc_req -> grant acc.
- Grant rules in ACC_BURST:
  - acc_req -> grant acc.
  - !acc_req -> grant core if core_req, and return to IDLE (the burst is abandoned).
- Entering and leaving ACC_BURST:
  - An acc grant in IDLE with acc_last=0 moves the state to ACC_BURST with beat_cnt=1.
  - Each granted beat in ACC_BURST increments beat_cnt.
  - The state returns to IDLE when a granted beat has acc_last=1.
  - The state also returns to IDLE when beat_cnt==MAX_BURST-1 is granted while core_req is high. In that case set yield=1, so the core wins the next cycle.
- yield flag: cleared after one cycle in IDLE, whatever that cycle grants.
- wait_cnt:
  - Increments when acc_req is high and acc is not granted.
  - Saturates at MAX_WAIT.
  - Clears on any acc grant or when acc_req is low.
- Grant outputs:
  - core_stall = core_req && !core_granted.
  - acc_gnt = acc granted.
  - Exactly one requester is granted per cycle, or none.
- dmem drive: dmem_en=1 on any grant. addr, din and we are muxed from the granted requester. we is forced to 0 when nothing is granted.
- Read return:
  - On a granted read (we==0), register rd_owner (core/acc) and its valid bit.
  - Next cycle, pulse the matching rvalid with rdata=dmem_dout.
  - The non-matching rdata output holds its previous value.
  - Writes never produce rvalid.
- Back-to-back reads from alternating owners each return in order, one per cycle.
- Reset mid-burst: state returns to IDLE, and any pending rvalid for a read issued in the reset cycle is suppressed.
- Simultaneous first requests (both request, wait_cnt=0, IDLE): core wins. Acc is forced through after MAX_WAIT denied cycles.

Decomposition:
- Shared package defines:
  - Owner encoding: OWN_CORE=1'b0, OWN_ACC=1'b1.
  - State encoding: ST_IDLE, ST_ACC_BURST.
  - Default MAX_WAIT and MAX_BURST.
- One natural sub-module: sat_counter (parameterised width/max, inc, clr, sync rst). It is instantiated for wait_cnt and beat_cnt.

Test Plan:
- Core-only traffic:
  - Core reads at 0x100, 0x104, 0x108 on consecutive cycles.
  - Required: core_stall=0 throughout, dmem_addr=0x40,0x41,0x42, and core_rvalid one cycle later with the BRAM data.
- Contention fairness:
  - Core and acc both request continuously (MAX_WAIT=4).
  - Required: core is granted for cycles 0-3, acc is granted in cycle 4 with core_stall=1, and wait_cnt returns to 0.
- Burst non-preemption and forced yield:
  - Acc issues a 10-beat burst with core_req held high from beat 2.
  - Required: acc_gnt for beats 0-7, then core granted one cycle, then acc resumes.
- Burst early end:
  - Acc issues a 3-beat burst with acc_last on beat 2.
  - Required: state is IDLE after beat 2, and a core request the next cycle is granted with no stall.
- Mixed read/write ordering:
  - Acc writes 0xDEADBEEF at 0x200 (we=4'hF), then the core reads 0x200 the next cycle.
  - Required: core_rvalid with core_rdata=0xDEADBEEF, and acc_rvalid never pulses.
- Reset mid-burst:
  - Assert rst at beat 3 of an acc read burst.
  - Required: acc_rvalid=0 the next cycle, acc_gnt=0 during rst, and state=IDLE afterwards.
